vga_timing_gen: RTL

//  Raster timing generator driving every sprite/ROM renderer: produces DrawX/DrawY, the active-video flag
//  (blank, 1 = visible pixel) and hs/vs for the VGA DAC. Counters advance on vga_clk when pix_en=1.

---
 rtl/vga_timing_pkg.sv | 18 +
 rtl/vga_axis_counter.sv | 30 +++
 rtl/vga_timing_gen.sv | 86 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing and shared coordinate type for the VGA timing generator.
package vga_timing_pkg;
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int COORD_MAX     = 1024;

    typedef logic [9:0] coord_t;

    function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: modulo counter plus visible-window and active-low sync decode of the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = H_VISIBLE_DEF,
    parameter int FRONT   = H_FRONT_DEF,
    parameter int SYNC    = H_SYNC_DEF,
    parameter int BACK    = H_BACK_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   inc,
    output coord_t cnt,
    output logic   visible,
    output logic   sync_n
);
    localparam int     TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam coord_t LAST  = coord_t'(TOTAL - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc)
            cnt <= (cnt == LAST) ? '0 : cnt + coord_t'(1);
    end

    // Decoded in int so a window edge at the full 1024 range cannot overflow.
    assign visible = int'(cnt) < VISIBLE;
    assign sync_n  = !((int'(cnt) >= VISIBLE + FRONT) && (int'(cnt) < VISIBLE + FRONT + SYNC));
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: registered DrawX/DrawY, blank, hs/vs, line/frame strobes and frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int FCNT_W    = 8
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              pix_en,
    output coord_t            DrawX,
    output coord_t            DrawY,
    output logic              blank,
    output logic              hs,
    output logic              vs,
    output logic              line_start,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);
    localparam int     H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int     V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);

    if (H_TOTAL > COORD_MAX) begin : g_h_too_big
        $error("vga_timing_gen: H_TOTAL %0d exceeds 10-bit counter", H_TOTAL);
    end
    if (V_TOTAL > COORD_MAX) begin : g_v_too_big
        $error("vga_timing_gen: V_TOTAL %0d exceeds 10-bit counter", V_TOTAL);
    end

    coord_t h_cnt, v_cnt;
    logic   h_vis, v_vis, h_sync_n, v_sync_n;
    logic   h_wrap, at_line0, at_frame0;

    assign h_wrap    = pix_en && (h_cnt == H_LAST);
    assign at_line0  = (h_cnt == '0);
    assign at_frame0 = at_line0 && (v_cnt == '0);

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h (
        .clk(vga_clk), .rst_n(reset_n), .inc(pix_en),
        .cnt(h_cnt), .visible(h_vis), .sync_n(h_sync_n)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v (
        .clk(vga_clk), .rst_n(reset_n), .inc(h_wrap),
        .cnt(v_cnt), .visible(v_vis), .sync_n(v_sync_n)
    );

    // Outputs show the decode of the pre-advance counters, so they trail them by one enabled edge.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (pix_en) begin
            DrawX       <= h_cnt;
            DrawY       <= v_cnt;
            blank       <= h_vis && v_vis;
            hs          <= h_sync_n;
            vs          <= v_sync_n;
            line_start  <= at_line0;
            frame_start <= at_frame0;
            if (at_frame0)
                frame_cnt <= frame_cnt + 1'b1;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end
endmodule
